// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the execute stage, mem_ctrl and the data memory.
// The slave modport is the controller's view; the master modport is the surrounding pipeline/memory.
interface mem_ctrl_if;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic [1:0]  stat;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;
  logic        dmem_error;

  modport slave (
    input  start, icode, valE, valA, valP, mem_read_data, dmem_error,
    output busy, done, valM, stat, mem_write_en, mem_read_en, mem_address, mem_write_data
  );

  modport master (
    output start, icode, valE, valA, valP, mem_read_data, dmem_error,
    input  busy, done, valM, stat, mem_write_en, mem_read_en, mem_address, mem_write_data
  );
endinterface

// File: rtl/mem_ctrl.sv
// Y86-64 memory-stage controller: decodes one request, runs a single data-memory access and reports valM/stat.
// Optional MEM_CTRL_BOUNDS_CHECK_EN rejects addresses above 16383 before any access is issued.
module mem_ctrl (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_HALT,
    OP_INV,
    OP_READ,
    OP_WRITE
  } op_t;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  function automatic op_t decode_op(input logic [3:0] code);
    op_t op;
    case (code)
      4'h4, 4'h8, 4'hA:             op = OP_WRITE;
      4'h5, 4'h9, 4'hB:             op = OP_READ;
      4'h0:                         op = OP_HALT;
      4'h1, 4'h2, 4'h3, 4'h6, 4'h7: op = OP_NONE;
      default:                      op = OP_INV;
    endcase
    return op;
  endfunction

  // ret and popq address the stack through valA; every other memory op uses valE.
  function automatic logic [63:0] pick_addr(input logic [3:0] code, input logic [63:0] e,
                                            input logic [63:0] a);
    return (code == 4'h9 || code == 4'hB) ? a : e;
  endfunction

  function automatic logic [63:0] pick_data(input logic [3:0] code, input logic [63:0] a,
                                            input logic [63:0] p);
    return (code == 4'h8) ? p : a;
  endfunction

  function automatic logic [1:0] nonmem_stat(input op_t op);
    logic [1:0] s;
    case (op)
      OP_HALT: s = STAT_HLT;
      OP_INV:  s = STAT_INS;
      default: s = STAT_AOK;
    endcase
    return s;
  endfunction

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  icode_q;
  logic [63:0] val_e_q;
  logic [63:0] val_a_q;
  logic [63:0] val_p_q;
  logic [63:0] valm_q;
  logic [1:0]  stat_q;
  op_t         op_in;
  op_t         op_q;
  logic        mem_in;
  logic        accept;
  logic        in_flight;

  assign op_in  = decode_op(bus.icode);
  assign op_q   = decode_op(icode_q);
  assign mem_in = (op_in == OP_READ) || (op_in == OP_WRITE);
  assign accept = (state_q == IDLE) && bus.start;

`ifdef MEM_CTRL_BOUNDS_CHECK_EN
  localparam logic [63:0] ADDR_LIMIT = 64'd16383;
  logic out_of_range;
  assign out_of_range = pick_addr(bus.icode, bus.valE, bus.valA) > ADDR_LIMIT;
`endif

  // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (mem_in) begin
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
            state_d = out_of_range ? DONE : ISSUE;
`else
            state_d = ISSUE;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured only when a request is accepted, so start pulses while busy are ignored.
  // stat is written at the edge that enters DONE, so it always describes the op being completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icode_q <= '0;
      val_e_q <= '0;
      val_a_q <= '0;
      val_p_q <= '0;
      valm_q  <= '0;
      stat_q  <= STAT_AOK;
    end else begin
      if (accept) begin
        icode_q <= bus.icode;
        val_e_q <= bus.valE;
        val_a_q <= bus.valA;
        val_p_q <= bus.valP;
        if (!mem_in) stat_q <= nonmem_stat(op_in);
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
        else if (out_of_range) stat_q <= STAT_ADR;
`endif
      end
      if (state_q == WAIT) begin
        if (op_q == OP_READ) valm_q <= bus.mem_read_data;
        stat_q <= bus.dmem_error ? STAT_ADR : STAT_AOK;
      end
    end
  end

  assign in_flight          = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.busy           = in_flight;
  assign bus.done           = (state_q == DONE);
  assign bus.valM           = valm_q;
  assign bus.stat           = stat_q;
  assign bus.mem_write_en   = (state_q == ISSUE) && (op_q == OP_WRITE);
  assign bus.mem_read_en    = (state_q == ISSUE) && (op_q == OP_READ);
  assign bus.mem_address    = in_flight ? pick_addr(icode_q, val_e_q, val_a_q) : '0;
  assign bus.mem_write_data = (in_flight && op_q == OP_WRITE) ?
                              pick_data(icode_q, val_a_q, val_p_q) : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a transaction-level model predicts each completion, a monitor
// checks the memory bus every cycle and pops the prediction whenever done pulses.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- data memory environment ----------------
  logic        err_inject;
  logic        env_bad;
  logic [63:0] env_mem [logic [63:0]];

  always @(posedge clk) begin
    if (rst) begin
      bus.dmem_error    <= 1'b0;
      bus.mem_read_data <= '0;
    end else if (bus.mem_write_en || bus.mem_read_en) begin
      env_bad = (bus.mem_address > 64'd16383) || err_inject;
      bus.dmem_error <= env_bad;
      if (bus.mem_write_en && !env_bad) env_mem[bus.mem_address] = bus.mem_write_data;
      if (bus.mem_read_en)
        bus.mem_read_data <= (!env_bad && env_mem.exists(bus.mem_address)) ?
                             env_mem[bus.mem_address] : 64'd0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        we;
    logic        re;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] valm;
    logic [1:0]  stat;
    int          lat;
    int          push_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          en_cnt  = 0;
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] model_valm = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Transaction-level rules: what the op does, where, and what it reports.
  function automatic exp_t predict(input logic [3:0] code, input logic [63:0] e,
                                   input logic [63:0] a, input logic [63:0] p, input logic inj);
    exp_t x;
    logic err;
    x.we = 1'b0; x.re = 1'b0; x.addr = '0; x.wdata = '0; x.lat = 1; x.push_cyc = 0;
    x.stat = 2'b00;
    case (code)
      4'h4: begin x.we = 1'b1; x.addr = e; x.wdata = a; end
      4'h8: begin x.we = 1'b1; x.addr = e; x.wdata = p; end
      4'hA: begin x.we = 1'b1; x.addr = e; x.wdata = a; end
      4'h5: begin x.re = 1'b1; x.addr = e; end
      4'h9, 4'hB: begin x.re = 1'b1; x.addr = a; end
      4'h0: x.stat = 2'b01;
      4'h1, 4'h2, 4'h3, 4'h6, 4'h7: x.stat = 2'b00;
      default: x.stat = 2'b11;
    endcase
    if (x.we || x.re) begin
`ifdef MEM_CTRL_BOUNDS_CHECK_EN
      if (x.addr > 64'd16383) begin
        x.we = 1'b0; x.re = 1'b0; x.addr = '0; x.wdata = '0; x.stat = 2'b10;
        x.valm = model_valm;
        return x;
      end
`endif
      x.lat = 3;
      err = (x.addr > 64'd16383) || inj;
      x.stat = err ? 2'b10 : 2'b00;
      if (x.we && !err) ref_mem[x.addr] = x.wdata;
      if (x.re) model_valm = (!err && ref_mem.exists(x.addr)) ? ref_mem[x.addr] : 64'd0;
    end
    x.valm = model_valm;
    return x;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      en_cnt = 0;
    end else begin
      check("en_exclusive", 64'(bus.mem_write_en & bus.mem_read_en), 64'd0);
      if (!bus.busy) begin
        check("idle_we", 64'(bus.mem_write_en), 64'd0);
        check("idle_re", 64'(bus.mem_read_en), 64'd0);
        check("idle_addr", bus.mem_address, 64'd0);
        check("idle_wdata", bus.mem_write_data, 64'd0);
      end else if (sb.size() == 0) begin
        check("busy_without_request", 64'd1, 64'(sb.size()));
      end else begin
        check("bus_addr", bus.mem_address, sb[0].addr);
        if (sb[0].we) check("bus_wdata", bus.mem_write_data, sb[0].wdata);
        if (bus.mem_write_en || bus.mem_read_en) begin
          en_cnt++;
          check("bus_we", 64'(bus.mem_write_en), 64'(sb[0].we));
          check("bus_re", 64'(bus.mem_read_en), 64'(sb[0].re));
        end
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("latency", 64'(cyc - e.push_cyc), 64'(e.lat));
          check("valM", bus.valM, e.valm);
          check("stat", 64'(bus.stat), 64'(e.stat));
          check("enable_cycles", 64'(en_cnt), 64'(e.we || e.re));
        end
        en_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic launch(input logic [3:0] code, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, input logic inj);
    exp_t x;
    wait_idle();
    x = predict(code, e, a, p, inj);
    x.push_cyc = cyc;
    sb.push_back(x);
    err_inject = inj;
    bus.icode  = code;
    bus.valE   = e;
    bus.valA   = a;
    bus.valP   = p;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
  endtask

  // hold=1 keeps start asserted with unrelated operands for the whole busy window.
  task automatic issue(input logic [3:0] code, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, input logic inj, input logic hold);
    int n = 0;
    launch(code, e, a, p, inj);
    if (hold) begin
      bus.start = 1'b1;
      bus.icode = 4'h4;
      bus.valE  = {$urandom, $urandom};
      bus.valA  = {$urandom, $urandom};
      bus.valP  = {$urandom, $urandom};
      while (bus.busy && n < 10) begin
        @(negedge clk);
        n++;
      end
      bus.start = 1'b0;
    end
  endtask

  initial begin
    logic [3:0]  code;
    logic [63:0] addr, e, a, p;
    int          n;
    rst = 1'b1;
    err_inject = 1'b0;
    bus.start = 1'b0;
    bus.icode = '0;
    bus.valE  = '0;
    bus.valA  = '0;
    bus.valP  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_valM", bus.valM, 64'd0);
    check("rst_stat", 64'(bus.stat), 64'd0);
    check("rst_we", 64'(bus.mem_write_en), 64'd0);
    check("rst_re", 64'(bus.mem_read_en), 64'd0);
    check("rst_addr", bus.mem_address, 64'd0);
    check("rst_wdata", bus.mem_write_data, 64'd0);
    rst = 1'b0;

    // Directed: write/read round trip, non-memory, halt, invalid, far address.
    issue(4'h4, 64'h10, 64'hDEAD, 64'h0, 1'b0, 1'b0);
    issue(4'h5, 64'h10, 64'h0, 64'h0, 1'b0, 1'b0);
    issue(4'h6, 64'h10, 64'h0, 64'h0, 1'b0, 1'b0);
    issue(4'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    issue(4'hC, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    issue(4'h9, 64'h0, 64'h20000, 64'h0, 1'b0, 1'b0);
    issue(4'hA, 64'h18, 64'h1234, 64'h0, 1'b0, 1'b1);
    issue(4'hB, 64'h0, 64'h18, 64'h0, 1'b0, 1'b1);
    issue(4'h5, 64'h10, 64'h0, 64'h0, 1'b1, 1'b0);
    issue(4'h5, 64'h10, 64'h0, 64'h0, 1'b0, 1'b0);

    // Reset during the WAIT of a read: no completion, everything cleared.
    launch(4'h5, 64'h10, 64'h0, 64'h0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_valM", bus.valM, 64'd0);
    check("abort_stat", 64'(bus.stat), 64'd0);
    check("abort_re", 64'(bus.mem_read_en), 64'd0);
    check("abort_addr", bus.mem_address, 64'd0);
    sb.delete();
    model_valm = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(4'h8, 64'h8, 64'h0, 64'h40, 1'b0, 1'b0);
    issue(4'h5, 64'h8, 64'h0, 64'h0, 1'b0, 1'b0);

    // Randomized traffic over a small aligned window plus occasional far addresses.
    for (int i = 0; i < 150; i++) begin
      code = 4'($urandom_range(0, 15));
      addr = ($urandom_range(0, 9) == 0) ? 64'h20000 + 64'(8 * $urandom_range(0, 3))
                                         : 64'(8 * $urandom_range(0, 31));
      e = {$urandom, $urandom};
      a = {$urandom, $urandom};
      p = {$urandom, $urandom};
      if (code == 4'h9 || code == 4'hB) a = addr;
      else e = addr;
      issue(code, e, a, p, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have start  in  1  request pulse from execute stage.
REQ-004 SHALL have icode  in  4  Y86-64 instruction code of the request.
REQ-005 SHALL have valE, valA, valP  in  64 each  execute result, register A operand, next PC.
REQ-006 SHALL have busy  out  1  high while a request is in flight.
REQ-007 SHALL have done  out  1  one-cycle completion pulse.
REQ-008 SHALL have valM  out  64  read result; stat  out  2  status (00 AOK, 01 HLT, 10 ADR, 11 INS).
REQ-009 SHALL have mem_write_en, mem_read_en  out  1 each; mem_address, mem_write_data  out  64 each: data-memory request.
REQ-010 SHALL have mem_read_data  in  64; dmem_error  in  1: data-memory response, valid one cycle after the issue edge.

Function
REQ-011 SHALL implement FSM IDLE, ISSUE, WAIT, DONE; busy=1 in ISSUE and WAIT.
REQ-012 In IDLE, start=1 at edge k SHALL latch icode/valE/valA/valP; start while busy SHALL be ignored.
REQ-013 Decode: 4 rmmovq write valA@valE; 8 call write valP@valE; A pushq write valA@valE; 5 mrmovq read @valE; 9 ret read @valA; B popq read @valA.
REQ-014 Memory ops SHALL go IDLE->ISSUE (k+1)->WAIT (k+2)->DONE (k+3)->IDLE; done=1 only in DONE.
REQ-015 Non-memory icodes 1,2,3,6,7 SHALL go IDLE->DONE (k+1), stat=AOK, valM unchanged.
REQ-016 icode 0 SHALL complete as in REQ-015 with stat=HLT; icode >B SHALL complete with stat=INS; neither SHALL touch memory.
REQ-017 Exactly one of mem_write_en/mem_read_en SHALL be high, only during ISSUE; never both.
REQ-018 mem_address/mem_write_data SHALL be stable from ISSUE through WAIT; 0 otherwise.
REQ-019 In WAIT, reads SHALL capture mem_read_data into valM; any op with dmem_error=1 SHALL set stat=ADR.
REQ-020 dmem_error is sticky in memory; controller SHALL report ADR on every memory op while it reads high.
REQ-021 valM and stat SHALL hold their values until the next completion.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, busy=0, done=0, valM=0, stat=AOK, all mem_* outputs 0, latched operands 0.
REQ-023 Reset mid-operation (ISSUE or WAIT) SHALL abort with no done pulse; first request after release SHALL behave normally.

Configuration
REQ-024 Macro MEM_CTRL_BOUNDS_CHECK_EN, when defined, SHALL check the address in IDLE: address >16383 skips ISSUE/WAIT, goes to DONE at k+1 with stat=ADR, no enable asserted.
REQ-025 Without MEM_CTRL_BOUNDS_CHECK_EN, every memory op SHALL issue and rely solely on dmem_error.

Verification
REQ-026 Reset then start, icode=4, valA=0xDEAD, valE=0x10 -> mem_write_en=1 at k+1, addr 0x10, data 0xDEAD; done at k+3, stat=00.
REQ-027 Then icode=5, valE=0x10 -> mem_read_en=1 at k+1; done at k+3, valM=0xDEAD, stat=00.
REQ-028 icode=6 -> done at k+1, no mem enable, stat=00; icode=0 -> stat=01; icode=0xC -> stat=11.
REQ-029 icode=9, valA=0x20000 with macro -> done at k+1, stat=10, no enable; without macro -> read issued, done k+3, stat=10 once dmem_error=1.
REQ-030 rst pulsed during WAIT of a read -> no done, outputs zero; following icode=8, valP=0x40, valE=0x8 -> write 0x40@0x8, done k+3.
